// File: rtl/usb_utmi_link_adapter.sv
// USB UTMI link adapter: bridges an 8/16-bit UTMI+ style link datapath to the
// 8-bit UTMI port of the soft PHY. TX goes through a byte FIFO with a start
// threshold and abort-on-underrun. RX bytes are packed into link words, and
// the RX error flag stays set for the rest of the packet.
module usb_utmi_link_adapter #(
    parameter int LINK_W       = 16,
    parameter int TX_DEPTH     = 16,
    parameter int START_THRESH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LINK_W-1:0]         link_txdata_i,
    input  logic                      link_txvalid_i,
    input  logic                      link_txvalidh_i,
    output logic                      link_txready_o,
    output logic [LINK_W-1:0]         link_rxdata_o,
    output logic                      link_rxvalid_o,
    output logic                      link_rxvalidh_o,
    output logic                      link_rxactive_o,
    output logic                      link_rxerror_o,
    output logic [7:0]                utmi_data_out_o,
    output logic                      utmi_txvalid_o,
    input  logic                      utmi_txready_i,
    input  logic [7:0]                utmi_data_in_i,
    input  logic                      utmi_rxvalid_i,
    input  logic                      utmi_rxactive_i,
    input  logic                      utmi_rxerror_i,
    output logic                      tx_underrun_o,
    output logic [$clog2(TX_DEPTH):0] tx_level_o
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_DEPTH  = LW'(TX_DEPTH);
    localparam logic [LW-1:0] C_BPW    = LW'(LINK_W / 8);
    localparam logic [LW-1:0] C_THRESH = LW'(START_THRESH);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_SEND, S_DRAIN, S_ABORT} tx_state_t;

    tx_state_t     r_state;
    tx_state_t     w_state_nx;
    logic [7:0]    r_mem [TX_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nx;
    logic          r_underrun;
    logic          r_tx_tail;   // low-byte-only word seen: packet data is complete
    logic          w_ready;
    logic          w_txvalid;
    logic          w_to_abort;
    logic          w_space_ok;
    logic          w_drain_done;
    logic          w_has_hi;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_nbytes;

    assign w_space_ok   = (C_DEPTH - r_level) >= C_BPW;
    // No pushes happen while draining, so the last byte leaves when one is left and the PHY takes it
    assign w_drain_done = (r_level == '0) || ((r_level == LW'(1)) && utmi_txready_i);

    // TX FSM next state and state-decoded handshake outputs
    always_comb begin
        w_state_nx = r_state;
        w_ready    = 1'b0;
        w_txvalid  = 1'b0;
        w_to_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = w_space_ok;
                if (link_txvalid_i && w_space_ok) w_state_nx = S_FILL;
            end
            S_FILL: begin
                w_ready = w_space_ok;
                if (!link_txvalid_i || (r_level >= C_THRESH)) w_state_nx = S_SEND;
            end
            S_SEND: begin
                w_ready   = w_space_ok;
                w_txvalid = 1'b1;
                if (!link_txvalid_i) begin
                    w_state_nx = w_drain_done ? S_IDLE : S_DRAIN;
                end else if ((r_level == '0) && utmi_txready_i) begin
                    w_state_nx = S_ABORT;
                    w_to_abort = 1'b1;
                end
            end
            S_DRAIN: begin
                w_txvalid = (r_level != '0);
                if (w_drain_done) w_state_nx = S_IDLE;
            end
            S_ABORT: begin
                w_ready = 1'b1;
                if (!link_txvalid_i) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_has_hi   = (LINK_W == 16) && link_txvalidh_i;
    assign w_flush    = (r_state == S_ABORT) || w_to_abort;
    assign w_push     = link_txvalid_i && w_ready && !w_flush && !r_tx_tail;
    assign w_pop      = w_txvalid && utmi_txready_i && (r_level != '0);
    assign w_nbytes   = !w_push ? 2'd0 : (w_has_hi ? 2'd2 : 2'd1);
    assign w_level_nx = w_flush ? '0 : (r_level + LW'(w_nbytes) - LW'(w_pop));

    // TX control state: FSM, FIFO pointers, occupancy, underrun pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_underrun <= 1'b0;
            r_tx_tail  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_level    <= w_level_nx;
            r_underrun <= w_to_abort;
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(w_nbytes);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
            end
            if (w_flush || !link_txvalid_i) r_tx_tail <= 1'b0;
            else if (w_push && !w_has_hi && (LINK_W == 16)) r_tx_tail <= 1'b1;
        end
    end

    // TX FIFO storage; low byte lands first so it is sent first
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= link_txdata_i[7:0];
            if (w_has_hi) r_mem[r_wptr + AW'(1)] <= link_txdata_i[LINK_W-1 -: 8];
        end
    end

    assign link_txready_o  = w_ready && !rst_i;
    assign utmi_txvalid_o  = w_txvalid;
    assign utmi_data_out_o = w_txvalid ? r_mem[r_rptr] : 8'h00;
    assign tx_underrun_o   = r_underrun;
    assign tx_level_o      = r_level;

    logic              r_act_in;
    logic              r_rxerr;
    logic              r_rx_vld;
    logic              r_rx_vldh;
    logic              r_rx_act;
    logic [LINK_W-1:0] r_rx_data;
    logic              w_rx_rise;

    assign w_rx_rise = utmi_rxactive_i && !r_act_in;

    // Sticky RX error, cleared when a new packet starts
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_act_in <= 1'b0;
            r_rxerr  <= 1'b0;
        end else begin
            r_act_in <= utmi_rxactive_i;
            if (utmi_rxerror_i) r_rxerr <= 1'b1;
            else if (w_rx_rise) r_rxerr <= 1'b0;
        end
    end

    generate
        if (LINK_W == 16) begin : g_rx16
            logic       r_lo_pend;
            logic [7:0] r_lo_byte;
            logic       w_rx_byte;
            logic       w_rx_fall;

            assign w_rx_byte = utmi_rxvalid_i && utmi_rxactive_i;
            assign w_rx_fall = !utmi_rxactive_i && r_act_in;

            // Pair bytes into words; a lone trailing byte is flushed after rxactive falls
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_lo_pend <= 1'b0;
                    r_lo_byte <= 8'h00;
                    r_rx_data <= '0;
                    r_rx_vld  <= 1'b0;
                    r_rx_vldh <= 1'b0;
                    r_rx_act  <= 1'b0;
                end else begin
                    r_rx_vld  <= 1'b0;
                    r_rx_vldh <= 1'b0;
                    r_rx_act  <= utmi_rxactive_i || (w_rx_fall && r_lo_pend);
                    if (w_rx_byte) begin
                        if (r_lo_pend) begin
                            r_rx_data <= {utmi_data_in_i, r_lo_byte};
                            r_rx_vld  <= 1'b1;
                            r_rx_vldh <= 1'b1;
                            r_lo_pend <= 1'b0;
                        end else begin
                            r_lo_byte <= utmi_data_in_i;
                            r_lo_pend <= 1'b1;
                        end
                    end else if (w_rx_fall) begin
                        if (r_lo_pend) begin
                            r_rx_data <= {8'h00, r_lo_byte};
                            r_rx_vld  <= 1'b1;
                        end
                        r_lo_pend <= 1'b0;
                    end
                end
            end
        end else begin : g_rx8
            // Plain one-cycle registered pass-through
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_rx_data <= '0;
                    r_rx_vld  <= 1'b0;
                    r_rx_vldh <= 1'b0;
                    r_rx_act  <= 1'b0;
                end else begin
                    r_rx_data <= utmi_data_in_i;
                    r_rx_vld  <= utmi_rxvalid_i;
                    r_rx_vldh <= 1'b0;
                    r_rx_act  <= utmi_rxactive_i;
                end
            end
        end
    endgenerate

    assign link_rxdata_o   = r_rx_data;
    assign link_rxvalid_o  = r_rx_vld;
    assign link_rxvalidh_o = r_rx_vldh;
    assign link_rxactive_o = r_rx_act;
    assign link_rxerror_o  = r_rxerr;

endmodule

// File: tb/tb_usb_utmi_link_adapter.sv
// Directed bench for usb_utmi_link_adapter (LINK_W=16, TX_DEPTH=16, START_THRESH=4).
module tb_usb_utmi_link_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] link_txdata_i;
    logic        link_txvalid_i;
    logic        link_txvalidh_i;
    logic        link_txready_o;
    logic [15:0] link_rxdata_o;
    logic        link_rxvalid_o;
    logic        link_rxvalidh_o;
    logic        link_rxactive_o;
    logic        link_rxerror_o;
    logic [7:0]  utmi_data_out_o;
    logic        utmi_txvalid_o;
    logic        utmi_txready_i;
    logic [7:0]  utmi_data_in_i;
    logic        utmi_rxvalid_i;
    logic        utmi_rxactive_i;
    logic        utmi_rxerror_i;
    logic        tx_underrun_o;
    logic [4:0]  tx_level_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    usb_utmi_link_adapter #(.LINK_W(16), .TX_DEPTH(16), .START_THRESH(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .link_txdata_i   (link_txdata_i),
        .link_txvalid_i  (link_txvalid_i),
        .link_txvalidh_i (link_txvalidh_i),
        .link_txready_o  (link_txready_o),
        .link_rxdata_o   (link_rxdata_o),
        .link_rxvalid_o  (link_rxvalid_o),
        .link_rxvalidh_o (link_rxvalidh_o),
        .link_rxactive_o (link_rxactive_o),
        .link_rxerror_o  (link_rxerror_o),
        .utmi_data_out_o (utmi_data_out_o),
        .utmi_txvalid_o  (utmi_txvalid_o),
        .utmi_txready_i  (utmi_txready_i),
        .utmi_data_in_i  (utmi_data_in_i),
        .utmi_rxvalid_i  (utmi_rxvalid_i),
        .utmi_rxactive_i (utmi_rxactive_i),
        .utmi_rxerror_i  (utmi_rxerror_i),
        .tx_underrun_o   (tx_underrun_o),
        .tx_level_o      (tx_level_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_tx(input logic v, input logic h, input logic [15:0] d);
        link_txvalid_i  = v;
        link_txvalidh_i = h;
        link_txdata_i   = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_txready"}, 32'(link_txready_o), 0);
        chk({tag, "_txvalid"}, 32'(utmi_txvalid_o), 0);
        chk({tag, "_dout"}, 32'(utmi_data_out_o), 0);
        chk({tag, "_level"}, 32'(tx_level_o), 0);
        chk({tag, "_underrun"}, 32'(tx_underrun_o), 0);
        chk({tag, "_rx"}, {11'd0, link_rxdata_o, link_rxvalid_o, link_rxvalidh_o,
                           link_rxactive_o, link_rxerror_o, 1'b0}, 0);
    endtask

    // Three-byte packet: 0x0201 then low-only 0x??03, then txvalid drops.
    task automatic send_short(input string tag);
        set_tx(1'b1, 1'b1, 16'h0201);
        mid; chk({tag, "_idle_rdy"}, 32'(link_txready_o), 1); nxt;
        set_tx(1'b1, 1'b0, 16'hAB03);
        mid; chk({tag, "_lvl2"}, 32'(tx_level_o), 2); nxt;
        set_tx(1'b0, 1'b0, 16'h0000);
        mid; chk({tag, "_lvl3"}, 32'(tx_level_o), 3);
        chk({tag, "_fill_txv"}, 32'(utmi_txvalid_o), 0); nxt;
        for (int i = 1; i <= 3; i++) begin
            mid; chk({tag, "_txv"}, 32'(utmi_txvalid_o), 1);
            chk({tag, "_byte"}, 32'(utmi_data_out_o), 32'(i)); nxt;
        end
        mid; chk({tag, "_end_txv"}, 32'(utmi_txvalid_o), 0);
        chk({tag, "_end_lvl"}, 32'(tx_level_o), 0); nxt;
        mid; chk({tag, "_no4th"}, 32'(utmi_txvalid_o), 0); nxt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_tx(1'b0, 1'b0, 16'h0000);
        utmi_txready_i  = 1'b1;
        utmi_data_in_i  = 8'h00;
        utmi_rxvalid_i  = 1'b0;
        utmi_rxactive_i = 1'b0;
        utmi_rxerror_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mid; chk_all_zero("reset"); nxt;
        rst = 1'b0;

        // Threshold start: 0x0201, 0x0403, 0x0605 with PHY always ready
        set_tx(1'b1, 1'b1, 16'h0201);
        mid; chk("thr_lvl0", 32'(tx_level_o), 0); chk("thr_rdy", 32'(link_txready_o), 1); nxt;
        set_tx(1'b1, 1'b1, 16'h0403);
        mid; chk("thr_lvl2", 32'(tx_level_o), 2); chk("thr_txv_fill", 32'(utmi_txvalid_o), 0); nxt;
        set_tx(1'b1, 1'b1, 16'h0605);
        mid; chk("thr_lvl4", 32'(tx_level_o), 4); chk("thr_txv_lvl4", 32'(utmi_txvalid_o), 0); nxt;
        set_tx(1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 6; i++) begin
            mid; chk("thr_txv", 32'(utmi_txvalid_o), 1);
            chk("thr_byte", 32'(utmi_data_out_o), 32'(i));
            chk("thr_level", 32'(tx_level_o), 32'(7 - i)); nxt;
        end
        mid; chk("thr_txv_fall", 32'(utmi_txvalid_o), 0); chk("thr_lvl_end", 32'(tx_level_o), 0); nxt;

        // Short packet sent on the txvalid fall
        send_short("short");

        // Underrun: five bytes, then txvalid held with nothing more to send
        set_tx(1'b1, 1'b1, 16'h0201); mid; nxt;
        set_tx(1'b1, 1'b1, 16'h0403); mid; nxt;
        set_tx(1'b1, 1'b0, 16'h0005);
        mid; chk("urun_lvl4", 32'(tx_level_o), 4); nxt;
        for (int i = 1; i <= 5; i++) begin
            mid; chk("urun_byte", 32'(utmi_data_out_o), 32'(i));
            chk("urun_pulse_early", 32'(tx_underrun_o), 0); nxt;
        end
        mid; chk("urun_empty", 32'(tx_level_o), 0); chk("urun_not_yet", 32'(tx_underrun_o), 0); nxt;
        set_tx(1'b1, 1'b1, 16'h0908);
        mid; chk("urun_pulse", 32'(tx_underrun_o), 1); chk("urun_txv_drop", 32'(utmi_txvalid_o), 0);
        chk("urun_abort_rdy", 32'(link_txready_o), 1); nxt;
        mid; chk("urun_pulse_once", 32'(tx_underrun_o), 0); chk("urun_discard", 32'(tx_level_o), 0);
        chk("urun_txv_abort", 32'(utmi_txvalid_o), 0); nxt;
        set_tx(1'b0, 1'b0, 16'h0000);
        mid; nxt;
        mid; chk("urun_idle_lvl", 32'(tx_level_o), 0); chk("urun_idle_txv", 32'(utmi_txvalid_o), 0);
        chk("urun_idle_rdy", 32'(link_txready_o), 1); nxt;

        // Full FIFO with the PHY stalled, then drain in order
        utmi_txready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_tx(1'b1, 1'b1, {8'(8'h12 + 2 * k), 8'(8'h11 + 2 * k)});
            mid; chk("full_lvl", 32'(tx_level_o), 32'(2 * k)); chk("full_rdy", 32'(link_txready_o), 1); nxt;
        end
        for (int k = 0; k < 2; k++) begin
            set_tx(1'b1, 1'b1, 16'h2221);
            mid; chk("full_lvl16", 32'(tx_level_o), 16); chk("full_rdy0", 32'(link_txready_o), 0); nxt;
        end
        set_tx(1'b0, 1'b0, 16'h0000);
        mid; chk("full_hold", 32'(tx_level_o), 16); chk("full_txv", 32'(utmi_txvalid_o), 1); nxt;
        utmi_txready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mid; chk("full_txv_drain", 32'(utmi_txvalid_o), 1);
            chk("full_byte", 32'(utmi_data_out_o), 32'(8'h11 + i)); nxt;
        end
        mid; chk("full_end_txv", 32'(utmi_txvalid_o), 0); chk("full_end_lvl", 32'(tx_level_o), 0); nxt;

        // RX: AA BB CC DD EE, error on BB, then rxactive falls
        utmi_rxactive_i = 1'b1;
        mid; nxt;
        utmi_rxvalid_i = 1'b1; utmi_data_in_i = 8'hAA;
        mid; chk("rx_act_rise", 32'(link_rxactive_o), 1); chk("rx_vld0", 32'(link_rxvalid_o), 0); nxt;
        utmi_data_in_i = 8'hBB; utmi_rxerror_i = 1'b1;
        mid; chk("rx_vld_half", 32'(link_rxvalid_o), 0); nxt;
        utmi_data_in_i = 8'hCC; utmi_rxerror_i = 1'b0;
        mid; chk("rx_w0", 32'(link_rxdata_o), 32'hBBAA); chk("rx_w0_vld", 32'(link_rxvalid_o), 1);
        chk("rx_w0_vldh", 32'(link_rxvalidh_o), 1); chk("rx_err_set", 32'(link_rxerror_o), 1); nxt;
        utmi_data_in_i = 8'hDD;
        mid; chk("rx_vld_gap", 32'(link_rxvalid_o), 0); nxt;
        utmi_data_in_i = 8'hEE;
        mid; chk("rx_w1", 32'(link_rxdata_o), 32'hDDCC); chk("rx_w1_vldh", 32'(link_rxvalidh_o), 1); nxt;
        utmi_rxvalid_i = 1'b0; utmi_rxactive_i = 1'b0;
        mid; chk("rx_fall_vld", 32'(link_rxvalid_o), 0); chk("rx_fall_act", 32'(link_rxactive_o), 1); nxt;
        mid; chk("rx_tail_lo", 32'(link_rxdata_o[7:0]), 32'hEE); chk("rx_tail_vld", 32'(link_rxvalid_o), 1);
        chk("rx_tail_vldh", 32'(link_rxvalidh_o), 0); chk("rx_tail_act", 32'(link_rxactive_o), 1); nxt;
        for (int i = 0; i < 3; i++) begin
            mid; chk("rx_act_off", 32'(link_rxactive_o), 0); chk("rx_err_hold", 32'(link_rxerror_o), 1);
            chk("rx_idle_vld", 32'(link_rxvalid_o), 0); nxt;
        end
        utmi_rxactive_i = 1'b1;
        mid; chk("rx_err_pre_rise", 32'(link_rxerror_o), 1); nxt;
        mid; chk("rx_err_clr", 32'(link_rxerror_o), 0); chk("rx_act2", 32'(link_rxactive_o), 1); nxt;
        utmi_rxactive_i = 1'b0;
        mid; chk("rx_act2_hold", 32'(link_rxactive_o), 1); nxt;
        mid; chk("rx_act2_off", 32'(link_rxactive_o), 0); chk("rx_nopend_vld", 32'(link_rxvalid_o), 0); nxt;

        // Reset asserted in SEND, then a fresh packet from IDLE
        set_tx(1'b1, 1'b1, 16'h0201); mid; nxt;
        set_tx(1'b1, 1'b1, 16'h0403); mid; nxt;
        set_tx(1'b1, 1'b1, 16'h0605); mid; nxt;
        mid; chk("rst_pre_send", 32'(utmi_txvalid_o), 1); chk("rst_pre_lvl", 32'(tx_level_o), 6);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        set_tx(1'b0, 1'b0, 16'h0000);
        nxt; nxt;
        rst = 1'b0;
        send_short("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
